alu: RTL and testbench
======================

# alu

Registered 16-bit arithmetic/logic unit for the 16-bit processor datapath. Each cycle it samples two operands and a 4-bit opcode, computes one of 16 operations, and registers the result with zero, negative and signed-overflow status flags. The result and flags feed the register-file write-back path and the branch/condition logic.

## Interface

- WIDTH, 16, operand/result width; only 16 is required to be verified.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- A  input  16  operand A (two's complement where signed).
- B  input  16  operand B; B[3:0] is the shift/rotate amount.
- opcode  input  4  operation select.
- out  output  16  registered result.
- zero_flag  output  1  registered; 1 when the registered out == 0.
- neg_flag  output  1  registered; equals out[15].
- overflow_flag  output  1  registered signed overflow, as defined per opcode.

One clock; reset is asynchronous and active-low.

## Operation

Opcode map (result truncated to 16 bits):
- 0 ADD: A+B. Overflow when A and B have the same sign and the result sign differs.
- 1 SUB: A−B. Overflow when A and B differ in sign and the result sign differs from A.
- 2 AND; 3 OR; 4 XOR; 5 NOT: ~A.
- 6 SHL: A << B[3:0], zero fill.
- 7 SHR: logical A >> B[3:0].
- 8 SAR: arithmetic A >>> B[3:0].
- 9 ROL and 10 ROR: rotate A by B[3:0]. Amount 0 passes A unchanged.
- 11 INC: A+1. Overflow when A = 0x7FFF.
- 12 DEC: A−1. Overflow when A = 0x8000.
- 13 SLT: out = 16'd1 if signed A < signed B, else 0.
- 14 MOV: out = B.
- 15 MUL: low 16 bits of the signed product A×B. Overflow when the full 32-bit signed product is not representable in 16 bits (upper 17 bits not all equal).

Flag rules:
- overflow_flag is 0 for every opcode not listed above with an overflow rule.
- zero_flag and neg_flag are derived from the computed result for every opcode, including logic, shift, SLT and MOV.
- Unsigned carry/borrow is not reported.

## Timing

- Fully registered. A, B and opcode are sampled on the rising clk edge. out and all flags update on that same edge, giving 1-cycle latency.
- Outputs hold between edges. There is no combinational path from inputs to outputs.
- A new operation can be issued every cycle, with no handshake and no stall.
- Reset: rst_n low immediately forces out = 0x0000, zero_flag = 0, neg_flag = 0, overflow_flag = 0. This applies regardless of clk, including mid-stream.
- On the first rising edge after rst_n deasserts, the unit captures the inputs normally.
- zero_flag is 0 during reset, even though out = 0 at that time.
- X-free: every one of the 16 opcodes is defined, and the default branch never produces X.

## Structure

- Shared package alu_pkg holds:
  - the WIDTH default;
  - a 4-bit opcode enum/localparams (OP_ADD … OP_MUL) with the values above. The decoder/control unit reuses it.
- Natural sub-module: alu_shifter. It is a combinational barrel shifter/rotator covering SHL, SHR, SAR, ROL and ROR, selected by a 3-bit mode.
- Remaining logic:
  - combinational result/flag mux;
  - one output register stage with asynchronous clear.
- MUL is a single-cycle signed multiply (synthesizer-inferred).

## Test plan

- Reset: assert rst_n = 0 with arbitrary inputs, no clock -> out = 0x0000 and all flags 0 immediately. Release rst_n -> the next edge captures the inputs.
- MUL/ADD/SUB: A = 7, B = 5.
  - op 15 -> out = 35 (0x0023), flags 000 one edge later.
  - op 0 -> 12.
  - op 1 -> 2.
  - A = 5, B = 7, op 1 -> 0xFFFE, neg = 1.
- Overflow:
  - ADD 0x7FFF+0x0001 -> 0x8000, neg = 1, ovf = 1.
  - SUB 0x8000−0x0001 -> 0x7FFF, ovf = 1.
  - INC 0x7FFF -> ovf = 1.
  - MUL 0x0100×0x0100 -> out 0x0000, zero = 1, ovf = 1.
- Shifts (A = 0x8001):
  - SHL by 1 -> 0x0002.
  - SHR by 1 -> 0x4000.
  - SAR by 1 -> 0xC000.
  - ROL by 1 -> 0x0003.
  - ROR by 4 -> 0x1800.
  - ROR by 0 -> 0x8001.
- Logic/compare:
  - AND 0xF0F0 & 0x0F0F -> 0, zero = 1.
  - NOT 0x0000 -> 0xFFFF, neg = 1.
  - SLT −1 vs 1 -> 1.
  - SLT 1 vs −1 -> 0, zero = 1.
  - MOV B = 0x1234 -> 0x1234.
- Back-to-back: change opcode every cycle across all 16 values. Each result appears exactly one edge after its inputs, with no bubbles and no X.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: default width, opcode encoding and
// barrel-shifter mode encoding. The decoder/control unit imports the same opcodes.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    // Opcode map; values are fixed by the instruction encoding.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SAR = 4'd8,
        OP_ROL = 4'd9,
        OP_ROR = 4'd10,
        OP_INC = 4'd11,
        OP_DEC = 4'd12,
        OP_SLT = 4'd13,
        OP_MOV = 4'd14,
        OP_MUL = 4'd15
    } alu_op_e;

    // Barrel shifter mode select.
    localparam logic [2:0] SH_SHL = 3'd0;
    localparam logic [2:0] SH_SHR = 3'd1;
    localparam logic [2:0] SH_SAR = 3'd2;
    localparam logic [2:0] SH_ROL = 3'd3;
    localparam logic [2:0] SH_ROR = 3'd4;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator: logical left/right, arithmetic right,
// rotate left/right. Unused mode codes pass the operand through unchanged.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    amt,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] y
);

    // Rotates are taken from a doubled copy of the operand, so amount 0
    // naturally yields the operand itself.
    logic [2*WIDTH-1:0] rol_wide;
    logic [2*WIDTH-1:0] ror_wide;

    assign rol_wide = {a, a} << amt;
    assign ror_wide = {a, a} >> amt;

    // Select the shift/rotate flavour.
    always_comb begin
        y = a;
        case (mode)
            SH_SHL:  y = a << amt;
            SH_SHR:  y = a >> amt;
            SH_SAR:  y = $unsigned($signed(a) >>> amt);
            SH_ROL:  y = rol_wide[2*WIDTH-1:WIDTH];
            SH_ROR:  y = ror_wide[WIDTH-1:0];
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: one combinational result/flag mux followed by a single
// output register with asynchronous active-low clear. Latency is one clock,
// a new operation may be issued every cycle; there is no handshake or stall.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             overflow_flag
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   inc;
    logic [WIDTH-1:0]   dec;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_hi;
    logic               slt;
    logic [2:0]         sh_mode;
    logic [WIDTH-1:0]   sh_out;
    logic [WIDTH-1:0]   result;
    logic               ovf;

    assign sum   = A + B;
    assign diff  = A - B;
    assign inc   = A + WIDTH'(1);
    assign dec   = A - WIDTH'(1);
    // Sign-extend to full width so the low 2*WIDTH bits of the product are
    // the exact signed product.
    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;
    // Product fits in WIDTH bits only when the top WIDTH+1 bits agree.
    assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
    assign slt   = $signed(A) < $signed(B);

    // Map shift/rotate opcodes onto the shifter mode.
    always_comb begin
        sh_mode = SH_SHL;
        case (opcode)
            OP_SHR:  sh_mode = SH_SHR;
            OP_SAR:  sh_mode = SH_SAR;
            OP_ROL:  sh_mode = SH_ROL;
            OP_ROR:  sh_mode = SH_ROR;
            default: sh_mode = SH_SHL;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_shifter (
        .a    (A),
        .amt  (B[SW-1:0]),
        .mode (sh_mode),
        .y    (sh_out)
    );

    // Result and signed-overflow select; every opcode is defined.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum;
                ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_NOT: result = ~A;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: result = sh_out;
            OP_INC: begin
                result = inc;
                ovf    = (A == MAX_POS);
            end
            OP_DEC: begin
                result = dec;
                ovf    = (A == MIN_NEG);
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            OP_MOV: result = B;
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                ovf    = !((&prod_hi) || !(|prod_hi));
            end
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

    // Output register; reset clears result and all flags immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out           <= '0;
            zero_flag     <= 1'b0;
            neg_flag      <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            out           <= result;
            zero_flag     <= (result == '0);
            neg_flag      <= result[WIDTH-1];
            overflow_flag <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations,
// plus randomized and back-to-back traffic against a behavioural model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode;
    logic [15:0] out;
    logic        zero_flag;
    logic        neg_flag;
    logic        overflow_flag;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [2:0]  znv;
    } vec_t;

    alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .opcode        (opcode),
        .out           (out),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .overflow_flag (overflow_flag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Works on integer values: overflow means the mathematical result left
    // the signed 16-bit range; rotates are done one bit at a time.
    function automatic void model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic [2:0] znv);
        int sa, sb, s, k;
        logic [15:0] t;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        k  = int'(b[3:0]);
        v  = 1'b0;
        s  = 0;
        r  = 16'h0;
        case (op)
            4'd0:  begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd1:  begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << k;
            4'd7:  r = a >> k;
            4'd8:  begin s = sa >>> k; r = s[15:0]; end
            4'd9:  begin t = a; for (int i = 0; i < k; i++) t = {t[14:0], t[15]}; r = t; end
            4'd10: begin t = a; for (int i = 0; i < k; i++) t = {t[0], t[15:1]}; r = t; end
            4'd11: begin s = sa + 1; r = s[15:0]; v = (s > 32767); end
            4'd12: begin s = sa - 1; r = s[15:0]; v = (s < -32768); end
            4'd13: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd14: r = b;
            default: begin s = sa * sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
        endcase
        znv = {(r == 16'h0), r[15], v};
    endfunction

    // ---------------- driver ----------------
    // Apply one operation at the falling edge, return just after the rising edge.
    task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Reset asserted between edges must clear outputs with no clock edge.
        #1;
        opcode = 4'd14;
        A      = 16'hDEAD;
        B      = 16'hBEEF;
        rst_n  = 1'b0;
        #1;
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== 19'h0) begin
            errors++;
            $display("FAIL reset_async got out=%h z=%b n=%b v=%b exp out=0000 z=0 n=0 v=0",
                     out, zero_flag, neg_flag, overflow_flag);
        end
        // Clock edges during reset must not load anything.
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== 19'h0) begin
            errors++;
            $display("FAIL reset_hold got out=%h z=%b n=%b v=%b exp out=0000 z=0 n=0 v=0",
                     out, zero_flag, neg_flag, overflow_flag);
        end
        // Release: the first edge captures the inputs (ADD 7+5).
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 4'd0;
        A      = 16'd7;
        B      = 16'd5;
        @(posedge clk);
        #1;
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== {16'h000C, 3'b000}) begin
            errors++;
            $display("FAIL reset_release got out=%h znv=%b%b%b exp out=000c znv=000",
                     out, zero_flag, neg_flag, overflow_flag);
        end
    endtask

    task automatic test_arith();
        vec_t tbl[4];
        tbl = '{'{4'd15, 16'd7, 16'd5, 16'h0023, 3'b000},
                '{4'd0,  16'd7, 16'd5, 16'h000C, 3'b000},
                '{4'd1,  16'd7, 16'd5, 16'h0002, 3'b000},
                '{4'd1,  16'd5, 16'd7, 16'hFFFE, 3'b010}};
        foreach (tbl[i]) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b);
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {tbl[i].r, tbl[i].znv}) begin
                errors++;
                $display("FAIL arith[%0d] op=%0d got out=%h znv=%b%b%b exp out=%h znv=%b",
                         i, tbl[i].op, out, zero_flag, neg_flag, overflow_flag, tbl[i].r, tbl[i].znv);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t tbl[7];
        tbl = '{'{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 3'b011},
                '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 3'b001},
                '{4'd11, 16'h7FFF, 16'h0000, 16'h8000, 3'b011},
                '{4'd15, 16'h0100, 16'h0100, 16'h0000, 3'b101},
                '{4'd12, 16'h8000, 16'h0000, 16'h7FFF, 3'b001},
                '{4'd12, 16'h0001, 16'h0000, 16'h0000, 3'b100},
                '{4'd15, 16'hFFFF, 16'h8000, 16'h8000, 3'b011}};
        foreach (tbl[i]) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b);
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {tbl[i].r, tbl[i].znv}) begin
                errors++;
                $display("FAIL overflow[%0d] op=%0d got out=%h znv=%b%b%b exp out=%h znv=%b",
                         i, tbl[i].op, out, zero_flag, neg_flag, overflow_flag, tbl[i].r, tbl[i].znv);
            end
        end
    endtask

    task automatic test_shifts();
        vec_t tbl[8];
        tbl = '{'{4'd6,  16'h8001, 16'h0001, 16'h0002, 3'b000},
                '{4'd7,  16'h8001, 16'h0001, 16'h4000, 3'b000},
                '{4'd8,  16'h8001, 16'h0001, 16'hC000, 3'b010},
                '{4'd9,  16'h8001, 16'h0001, 16'h0003, 3'b000},
                '{4'd10, 16'h8001, 16'h0004, 16'h1800, 3'b000},
                '{4'd10, 16'h8001, 16'h0000, 16'h8001, 3'b010},
                '{4'd6,  16'h8001, 16'h0011, 16'h0002, 3'b000},
                '{4'd8,  16'h8000, 16'h000F, 16'hFFFF, 3'b010}};
        foreach (tbl[i]) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b);
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {tbl[i].r, tbl[i].znv}) begin
                errors++;
                $display("FAIL shift[%0d] op=%0d got out=%h znv=%b%b%b exp out=%h znv=%b",
                         i, tbl[i].op, out, zero_flag, neg_flag, overflow_flag, tbl[i].r, tbl[i].znv);
            end
        end
    endtask

    task automatic test_logic();
        vec_t tbl[7];
        tbl = '{'{4'd2,  16'hF0F0, 16'h0F0F, 16'h0000, 3'b100},
                '{4'd5,  16'h0000, 16'h0000, 16'hFFFF, 3'b010},
                '{4'd13, 16'hFFFF, 16'h0001, 16'h0001, 3'b000},
                '{4'd13, 16'h0001, 16'hFFFF, 16'h0000, 3'b100},
                '{4'd14, 16'h5555, 16'h1234, 16'h1234, 3'b000},
                '{4'd3,  16'hF0F0, 16'h0F0F, 16'hFFFF, 3'b010},
                '{4'd4,  16'hA5A5, 16'hA5A5, 16'h0000, 3'b100}};
        foreach (tbl[i]) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b);
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {tbl[i].r, tbl[i].znv}) begin
                errors++;
                $display("FAIL logic[%0d] op=%0d got out=%h znv=%b%b%b exp out=%h znv=%b",
                         i, tbl[i].op, out, zero_flag, neg_flag, overflow_flag, tbl[i].r, tbl[i].znv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r, prev_r;
        logic [2:0]  exp_f, prev_f;
        logic [15:0] a, b;
        prev_r = out;
        prev_f = {zero_flag, neg_flag, overflow_flag};
        for (int c = 0; c < 48; c++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            opcode = 4'(c % 16);
            A      = a;
            B      = b;
            #1;
            // New inputs must not reach the outputs before the clock edge.
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {prev_r, prev_f}) begin
                errors++;
                $display("FAIL b2b_hold[%0d] got out=%h znv=%b%b%b exp out=%h znv=%b",
                         c, out, zero_flag, neg_flag, overflow_flag, prev_r, prev_f);
            end
            model(4'(c % 16), a, b, exp_r, exp_f);
            @(posedge clk);
            #1;
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {exp_r, exp_f}) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h got out=%h znv=%b%b%b exp out=%h znv=%b",
                         c, c % 16, a, b, out, zero_flag, neg_flag, overflow_flag, exp_r, exp_f);
            end
            prev_r = exp_r;
            prev_f = exp_f;
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [2:0]  flg_q[$];
        logic [15:0] a, b, r;
        logic [3:0]  op;
        logic [2:0]  f;
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            // Bias operands toward the signed boundaries now and then.
            case ($urandom_range(0, 3))
                0:       a = 16'h7FFF;
                1:       a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            model(op, a, b, r, f);
            exp_q.push_back(r);
            flg_q.push_back(f);
            drive_op(op, a, b);
            r = exp_q.pop_front();
            f = flg_q.pop_front();
            checks++;
            if ({out, zero_flag, neg_flag, overflow_flag} !== {r, f}) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got out=%h znv=%b%b%b exp out=%h znv=%b",
                         n, op, a, b, out, zero_flag, neg_flag, overflow_flag, r, f);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_op(4'd5, 16'h0F00, 16'h0000);
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== {16'hF0FF, 3'b010}) begin
            errors++;
            $display("FAIL midrst_pre got out=%h znv=%b%b%b exp out=f0ff znv=010",
                     out, zero_flag, neg_flag, overflow_flag);
        end
        // Assert reset between edges mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== 19'h0) begin
            errors++;
            $display("FAIL midrst_clear got out=%h znv=%b%b%b exp out=0000 znv=000",
                     out, zero_flag, neg_flag, overflow_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(4'd15, 16'hFFFD, 16'h0003);
        checks++;
        if ({out, zero_flag, neg_flag, overflow_flag} !== {16'hFFF7, 3'b010}) begin
            errors++;
            $display("FAIL midrst_resume got out=%h znv=%b%b%b exp out=fff7 znv=010",
                     out, zero_flag, neg_flag, overflow_flag);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        A      = 16'h0;
        B      = 16'h0;
        opcode = 4'h0;
        test_reset();
        test_arith();
        test_overflow();
        test_shifts();
        test_logic();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
